// File: rtl/shift4_deserializer_if.sv
// Bus bundle for the LSB-first serial-to-parallel receiver.
// The slave side is the deserializer. The master side is the link and consumer pair that drives it.
interface shift4_deserializer_if #(
  parameter int WIDTH = 4
);
  localparam int CW = $clog2(WIDTH + 1);

  // Serial link side
  logic             clear;
  logic             ena;
  logic             sin;

  // Parallel consumer side
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             q_ready;

  // Status
  logic [CW-1:0]    bit_cnt;
  logic             overrun;

  modport slave (
    input  clear,
    input  ena,
    input  sin,
    input  q_ready,
    output q,
    output q_valid,
    output bit_cnt,
    output overrun
  );

  modport master (
    output clear,
    output ena,
    output sin,
    output q_ready,
    input  q,
    input  q_valid,
    input  bit_cnt,
    input  overrun
  );
endinterface

// File: rtl/shift4_deserializer.sv
// Rebuilds parallel words from an LSB-first serial stream.
// Completed words are offered on a valid/ready output with a one-word holding register.
// A word that completes while the holding register is full and not being drained is dropped.
// When that happens, the sticky overrun flag is raised.
module shift4_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  shift4_deserializer_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  // Candidate shift-register contents if this cycle's sample is taken.
  // New bits enter at the MSB, so the first bit received ends up at bit 0.
  logic [WIDTH-1:0] shifted;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign shifted[gi] = sreg_q[gi + 1];
    end
  endgenerate
  assign shifted[WIDTH-1] = bus.sin;

  // A word is complete when the final bit of the word is sampled.
  logic complete;
  assign complete = bus.ena && (cnt_q == LAST_BIT);

  // Next-state logic.
  // Clear restarts the frame but leaves the held word alone.
  always_comb begin
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (bus.clear) begin
      sreg_d    = '0;
      cnt_d     = '0;
      overrun_d = 1'b0;
    end else begin
      if (bus.ena) begin
        sreg_d = shifted;
        cnt_d  = complete ? '0 : cnt_q + CW'(1);
      end

      if (complete) begin
        // Holding register is free, or is being drained this very edge.
        if (!valid_q || bus.q_ready) begin
          word_d  = shifted;
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else if (valid_q && bus.q_ready) begin
        valid_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset.
  // Reset drops any partial word and any held word.
  always_ff @(posedge clk) begin
    if (reset) begin
      sreg_q    <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.q       = word_q;
  assign bus.q_valid = valid_q;
  assign bus.bit_cnt = cnt_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_shift4_deserializer.sv
// Self-checking bench for shift4_deserializer.
// Directed scenarios use hand-derived constants. The random phase compares against a word-level model.
module tb_shift4_deserializer;

  localparam int WIDTH = 4;

  logic clk;
  logic reset;

  shift4_deserializer_if #(.WIDTH(WIDTH)) bus ();

  shift4_deserializer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: accumulates bits arithmetically and holds one word.
  int         m_cnt;
  int         m_acc;
  logic [3:0] m_q;
  logic       m_v;
  logic       m_ovr;

  task automatic model_step(input logic r, input logic c, input logic e,
                            input logic s, input logic rdy);
    bit done;
    int word;
    done = 0;
    word = 0;
    if (r) begin
      m_cnt = 0; m_acc = 0; m_q = '0; m_v = 0; m_ovr = 0;
    end else if (c) begin
      m_cnt = 0; m_acc = 0; m_ovr = 0;
    end else begin
      if (e) begin
        m_acc = m_acc + (int'(s) << m_cnt);
        m_cnt = m_cnt + 1;
        if (m_cnt == WIDTH) begin
          done  = 1;
          word  = m_acc;
          m_cnt = 0;
          m_acc = 0;
        end
      end
      if (done) begin
        if (!m_v || rdy) begin
          m_q = word[3:0];
          m_v = 1;
        end else begin
          m_ovr = 1;
        end
      end else if (m_v && rdy) begin
        m_v = 0;
      end
    end
  endtask

  // Apply one cycle of inputs, clock it, update the model, then settle past the edge.
  task automatic cyc(input logic r, input logic c, input logic e,
                     input logic s, input logic rdy);
    reset       = r;
    bus.clear   = c;
    bus.ena     = e;
    bus.sin     = s;
    bus.q_ready = rdy;
    @(posedge clk);
    if (!r && !c && bus.q_valid && rdy)
      $display("xfer q=%h", bus.q);
    model_step(r, c, e, s, rdy);
    #1;
  endtask

  task automatic send_word(input logic [3:0] w, input logic rdy);
    logic [3:0] tmp;
    tmp = w;
    for (int i = 0; i < WIDTH; i++) cyc(0, 0, 1, tmp[i], rdy);
  endtask

  task automatic test_reset;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    if (bus.q !== 4'h0) begin errors++; $display("FAIL reset_q got %h want 0", bus.q); end
    checks++;
    if (bus.q_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.q_valid); end
    checks++;
    if (bus.bit_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", bus.bit_cnt); end
    checks++;
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b want 0", bus.overrun); end
    checks++;
    $display("test_reset done");
  endtask

  task automatic test_basic;
    cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 1, 0, 1);
    if (bus.bit_cnt !== 3'd2) begin errors++; $display("FAIL basic_cnt got %0d want 2", bus.bit_cnt); end
    checks++;
    cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 1, 1, 1);
    if (bus.q !== 4'hD || bus.q_valid !== 1'b1) begin
      errors++; $display("FAIL basic_word got q=%h v=%b want q=d v=1", bus.q, bus.q_valid);
    end
    checks++;
    cyc(0, 0, 0, 0, 1);
    if (bus.q_valid !== 1'b0 || bus.q !== 4'hD) begin
      errors++; $display("FAIL basic_once got q=%h v=%b want q=d v=0", bus.q, bus.q_valid);
    end
    checks++;
    $display("test_basic done");
  endtask

  task automatic test_gaps;
    logic [3:0] bits;
    bits = 4'hD;
    for (int i = 0; i < WIDTH; i++) begin
      cyc(0, 0, 1, bits[i], 1);
      if (i < WIDTH - 1) begin
        cyc(0, 0, 0, ~bits[i], 1);
        cyc(0, 0, 0, 1, 1);
        if (bus.bit_cnt !== 3'(i + 1)) begin
          errors++; $display("FAIL gap_cnt got %0d want %0d", bus.bit_cnt, i + 1);
        end
        checks++;
        if (bus.q_valid !== 1'b0) begin errors++; $display("FAIL gap_valid got %b want 0", bus.q_valid); end
        checks++;
      end
    end
    if (bus.q !== 4'hD || bus.q_valid !== 1'b1) begin
      errors++; $display("FAIL gap_word got q=%h v=%b want q=d v=1", bus.q, bus.q_valid);
    end
    checks++;
    cyc(0, 0, 0, 0, 1);
    if (bus.q_valid !== 1'b0) begin errors++; $display("FAIL gap_once got %b want 0", bus.q_valid); end
    checks++;
    $display("test_gaps done");
  endtask

  task automatic test_overrun;
    send_word(4'h3, 0);
    if (bus.q !== 4'h3 || bus.q_valid !== 1'b1 || bus.overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_first got q=%h v=%b o=%b want q=3 v=1 o=0", bus.q, bus.q_valid, bus.overrun);
    end
    checks++;
    send_word(4'hA, 0);
    if (bus.q !== 4'h3 || bus.q_valid !== 1'b1 || bus.overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_drop got q=%h v=%b o=%b want q=3 v=1 o=1", bus.q, bus.q_valid, bus.overrun);
    end
    checks++;
    cyc(0, 0, 0, 0, 0);
    if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", bus.overrun); end
    checks++;
    cyc(0, 1, 1, 1, 1);
    if (bus.q !== 4'h3 || bus.q_valid !== 1'b1 || bus.overrun !== 1'b0 || bus.bit_cnt !== 3'd0) begin
      errors++; $display("FAIL ovr_clear got q=%h v=%b o=%b c=%0d want q=3 v=1 o=0 c=0",
                         bus.q, bus.q_valid, bus.overrun, bus.bit_cnt);
    end
    checks++;
    $display("test_overrun done");
  endtask

  task automatic test_collide;
    // 4'h3 is still held. Drain it on the same edge that 4'h5 completes.
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 0, 1);
    if (bus.q !== 4'h5 || bus.q_valid !== 1'b1 || bus.overrun !== 1'b0) begin
      errors++; $display("FAIL collide got q=%h v=%b o=%b want q=5 v=1 o=0", bus.q, bus.q_valid, bus.overrun);
    end
    checks++;
    cyc(0, 0, 0, 0, 1);
    if (bus.q_valid !== 1'b0) begin errors++; $display("FAIL collide_drain got %b want 0", bus.q_valid); end
    checks++;
    $display("test_collide done");
  endtask

  task automatic test_abort;
    cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 1, 1, 1);
    cyc(1, 0, 0, 0, 1);
    if (bus.bit_cnt !== 3'd0 || bus.q !== 4'h0) begin
      errors++; $display("FAIL abort_reset got c=%0d q=%h want c=0 q=0", bus.bit_cnt, bus.q);
    end
    checks++;
    send_word(4'h9, 1);
    if (bus.q !== 4'h9 || bus.q_valid !== 1'b1) begin
      errors++; $display("FAIL abort_reset_word got q=%h v=%b want q=9 v=1", bus.q, bus.q_valid);
    end
    checks++;
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 1, 1);
    cyc(0, 1, 0, 0, 1);
    send_word(4'h9, 1);
    if (bus.q !== 4'h9 || bus.q_valid !== 1'b1) begin
      errors++; $display("FAIL abort_clear_word got q=%h v=%b want q=9 v=1", bus.q, bus.q_valid);
    end
    checks++;
    cyc(0, 0, 0, 0, 1);
    $display("test_abort done");
  endtask

  task automatic test_random;
    logic r, c, e, s, rdy;
    for (int n = 0; n < 400; n++) begin
      r   = ($urandom_range(0, 99) == 0);
      c   = ($urandom_range(0, 19) == 0);
      e   = ($urandom_range(0, 9) < 7);
      s   = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 9) < 4);
      cyc(r, c, e, s, rdy);
      if (bus.q !== m_q || bus.q_valid !== m_v || bus.overrun !== m_ovr || bus.bit_cnt !== 3'(m_cnt)) begin
        errors++;
        $display("FAIL random cyc %0d got q=%h v=%b o=%b c=%0d want q=%h v=%b o=%b c=%0d",
                 n, bus.q, bus.q_valid, bus.overrun, bus.bit_cnt, m_q, m_v, m_ovr, m_cnt);
      end
      checks++;
    end
    $display("test_random done");
  endtask

  initial begin
    reset = 1'b1;
    bus.clear = 1'b0;
    bus.ena = 1'b0;
    bus.sin = 1'b0;
    bus.q_ready = 1'b0;
    m_cnt = 0; m_acc = 0; m_q = '0; m_v = 0; m_ovr = 0;
    test_reset();
    test_basic();
    test_gaps();
    test_overrun();
    test_collide();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
